clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
- Parametrised multi-channel clock divider and tick generator.
- Each of NCH channels produces a 50 % duty square wave (clkout) and a one-cycle tick pulse per toggle.
- Each channel's half-period is runtime-programmable through a shadow-register write port, applied glitch-free at the channel's next terminal count.
- Feeds display scan, debounce sampling and 1 Hz timekeeping logic from the single system clock.

Parameters:
- NCH, 4: number of independent divider channels.
- CNT_W, 32: width of the counters and of the half-period values.
- DEF_HALF, 50000000: reset half-period in clk cycles; gives 1 Hz output at 100 MHz.
- CH_W, max(1,$clog2(NCH)): width of the channel-select port.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- wr  in  1  half-period write strobe, single cycle.
- wr_ch  in  CH_W  target channel for wr.
- wr_half  in  CNT_W  new half-period in clk cycles.
- clkout  out  NCH  divided square-wave outputs, registered.
- tick  out  NCH  one-clk pulse asserted in the cycle clkout[i] toggles, registered.
- pend  out  NCH  shadow value written but not yet applied.

Behaviour:
- Per-channel state: cnt[i] (CNT_W), active half[i], shadow[i], pend[i].
- Reset (async, rst=1): cnt=0, clkout=0, tick=0, half=DEF_HALF, shadow=DEF_HALF, pend=0. Takes effect immediately, without a clock edge. Release is synchronous to the next rising edge.
- Effective half-period: h = half[i]; a value of 0 is treated as h = 1.
- en[i]=1, cnt==h-1 (terminal):
  - cnt<=0, clkout[i]<=~clkout[i], tick[i]<=1.
  - If pend[i]: half<=shadow, pend<=0.
- en[i]=1, not terminal: cnt<=cnt+1, tick[i]<=0.
- Output period is 2*h cycles. h=1 gives clk/2 with tick held at 1 continuously.
- First toggle: with en high from reset release, clkout rises on the h-th rising edge; tick is high in that same cycle.
- en[i]=0:
  - cnt and clkout hold; tick<=0.
  - If pend: half<=shadow, pend<=0, cnt<=0. The output is static, so this is safe.
  - Re-enabling resumes counting from the held cnt.
- Write (wr=1):
  - If wr_ch < NCH: shadow[wr_ch]<=wr_half, pend<=1.
  - If wr_ch >= NCH: write ignored, no state change.
  - A second write before application overwrites shadow; last write wins.
- Simultaneous wr and terminal on the same channel: wr_half is applied directly as the new half, pend stays 0. The write is never lost or delayed a full period.
- Active half never changes mid half-period while enabled, so there are no runt pulses.
- Channels are fully independent; writes to one channel never disturb another's counter.

Optional Feature:
- Macro: CLOCK_DIVIDER_MULTI_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - sync_in=1 forces, on that edge, all channels to cnt<=0, clkout<=0, tick<=0, and applies any pending shadows (pend<=0).
  - Takes priority over en and terminal logic; a wr in the same cycle is captured into shadow with pend=1.
  - Used for phase-aligning all channels.
- Undefined: port absent, no realignment logic.

Test Plan (NCH=3, CNT_W=8, DEF_HALF=3):
- Release rst, en=3'b001 -> clkout[0] rises on edge 3, falls on edge 6 (period 6); tick[0] high on edges 3, 6, 9…; clkout[2:1] and tick[2:1] stay 0.
- At edge 1 write ch0 half=5 -> pend[0]=1; toggle still at edge 3 (old h); next toggles at edges 8, 13; pend[0] clears at edge 3.
- Write ch1 half=0, en[1]=1 -> clkout[1] toggles every cycle, tick[1] constant 1.
- Drop en[0] at cnt=1 for 4 cycles -> clkout[0] and cnt hold, tick[0]=0; re-enable -> toggle after 1 further edge when h=3.
- Write wr_ch=3 half=9 -> no pend bit set, all channels unchanged.
- Assert rst asynchronously between edges mid-run -> clkout, tick, pend go 0 immediately; after release, period returns to 6 regardless of prior writes.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel 50% duty clock divider / tick generator with shadowed half-period writes.
// Optional phase-align input sync_in is enabled by defining CLOCK_DIVIDER_MULTI_SYNC_EN.
module clock_divider_multi #(
   parameter int NCH      = 4,
   parameter int CNT_W    = 32,
   parameter int DEF_HALF = 50000000,
   parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
   input  logic             wr,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [CNT_W-1:0] wr_half,
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
   input  logic             sync_in,
`endif
   output logic [NCH-1:0]   clkout,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   pend
);

   logic [CNT_W-1:0] cnt_q    [NCH];
   logic [CNT_W-1:0] cnt_d    [NCH];
   logic [CNT_W-1:0] half_q   [NCH];
   logic [CNT_W-1:0] half_d   [NCH];
   logic [CNT_W-1:0] shadow_q [NCH];
   logic [CNT_W-1:0] shadow_d [NCH];
   logic [NCH-1:0]   clk_q, clk_d;
   logic [NCH-1:0]   tick_q, tick_d;
   logic [NCH-1:0]   pend_q, pend_d;
   logic [NCH-1:0]   term;
   logic [NCH-1:0]   wr_hit;

   always_comb begin
      cnt_d    = cnt_q;
      half_d   = half_q;
      shadow_d = shadow_q;
      clk_d    = clk_q;
      pend_d   = pend_q;
      tick_d   = '0;
      term     = '0;
      wr_hit   = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         // Out-of-range wr_ch matches no channel, so such writes are dropped.
         wr_hit[i] = wr && (wr_ch == CH_W'(i));
         if (half_q[i] == '0)
            term[i] = (cnt_q[i] == '0);
         else
            term[i] = (cnt_q[i] == half_q[i] - CNT_W'(1));
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
         if (sync_in) begin
            cnt_d[i] = '0;
            clk_d[i] = 1'b0;
            if (pend_q[i]) begin
               half_d[i] = shadow_q[i];
               pend_d[i] = 1'b0;
            end
            if (wr_hit[i]) begin
               shadow_d[i] = wr_half;
               pend_d[i]   = 1'b1;
            end
         end else
`endif
         if (en[i]) begin
            if (term[i]) begin
               cnt_d[i]  = '0;
               clk_d[i]  = ~clk_q[i];
               tick_d[i] = 1'b1;
               // A write landing on the terminal edge takes effect immediately.
               if (wr_hit[i]) begin
                  half_d[i]   = wr_half;
                  shadow_d[i] = wr_half;
                  pend_d[i]   = 1'b0;
               end else if (pend_q[i]) begin
                  half_d[i] = shadow_q[i];
                  pend_d[i] = 1'b0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
               if (wr_hit[i]) begin
                  shadow_d[i] = wr_half;
                  pend_d[i]   = 1'b1;
               end
            end
         end else begin
            if (wr_hit[i]) begin
               shadow_d[i] = wr_half;
               pend_d[i]   = 1'b1;
            end else if (pend_q[i]) begin
               half_d[i] = shadow_q[i];
               pend_d[i] = 1'b0;
               cnt_d[i]  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            cnt_q[i]    <= '0;
            half_q[i]   <= CNT_W'(DEF_HALF);
            shadow_q[i] <= CNT_W'(DEF_HALF);
         end
         clk_q  <= '0;
         tick_q <= '0;
         pend_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         shadow_q <= shadow_d;
         clk_q    <= clk_d;
         tick_q   <= tick_d;
         pend_q   <= pend_d;
      end
   end

   assign clkout = clk_q;
   assign tick   = tick_q;
   assign pend   = pend_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Table-driven bench for clock_divider_multi (NCH=3, CNT_W=8, DEF_HALF=3) with an expectation queue.
module tb_clock_divider_multi;

   localparam int NCH      = 3;
   localparam int CNT_W    = 8;
   localparam int DEF_HALF = 3;
   localparam int CH_W     = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH-1:0]   en;
   logic             wr;
   logic [CH_W-1:0]  wr_ch;
   logic [CNT_W-1:0] wr_half;
   logic [NCH-1:0]   clkout, tick, pend;
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
   logic             sync_in = 1'b0;
`endif

   always #5 clk = ~clk;

   clock_divider_multi #(
      .NCH(NCH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF), .CH_W(CH_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_ch(wr_ch), .wr_half(wr_half),
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
      .sync_in(sync_in),
`endif
      .clkout(clkout), .tick(tick), .pend(pend)
   );

   typedef struct {
      logic [2:0] en;
      logic       wr;
      logic [1:0] ch;
      logic [7:0] half;
      logic [2:0] clk;
      logic [2:0] tick;
      logic [2:0] pend;
   } vec_t;

   typedef struct {
      logic [2:0] clk;
      logic [2:0] tick;
      logic [2:0] pend;
   } exp_t;

   vec_t tbl [0:26];
   exp_t exp_q [$];
   int   errors = 0;
   int   checks = 0;

   task automatic cmp(input string name, input int idx, input logic [2:0] act, input logic [2:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, req);
      end
   endtask

   task automatic pop_check(input string name, input int idx);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s[%0d]: got empty queue expected entry", name, idx);
      end else begin
         e = exp_q.pop_front();
         cmp({name, ".clkout"}, idx, clkout, e.clk);
         cmp({name, ".tick"},   idx, tick,   e.tick);
         cmp({name, ".pend"},   idx, pend,   e.pend);
      end
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         en      = tbl[i].en;
         wr      = tbl[i].wr;
         wr_ch   = tbl[i].ch;
         wr_half = tbl[i].half;
         exp_q.push_back('{clk: tbl[i].clk, tick: tbl[i].tick, pend: tbl[i].pend});
         @(posedge clk);
         #1;
         pop_check("vec", i);
      end
      wr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Phase B: write ch0 half=5 at edge 1, ch1 half=0, invalid channel, ch2 write pending.
      tbl[0]  = '{3'b001, 1'b1, 2'd0, 8'd5, 3'b000, 3'b000, 3'b001};
      tbl[1]  = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001};
      tbl[2]  = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b000};
      tbl[3]  = '{3'b001, 1'b1, 2'd1, 8'd0, 3'b001, 3'b000, 3'b010};
      tbl[4]  = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b000};
      tbl[5]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b011, 3'b010, 3'b000};
      tbl[6]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b001, 3'b010, 3'b000};
      tbl[7]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b010, 3'b011, 3'b000};
      tbl[8]  = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b010, 3'b000};
      tbl[9]  = '{3'b011, 1'b1, 2'd3, 8'd9, 3'b010, 3'b010, 3'b000};
      tbl[10] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b000, 3'b010, 3'b000};
      tbl[11] = '{3'b011, 1'b0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b000};
      tbl[12] = '{3'b011, 1'b1, 2'd2, 8'd7, 3'b001, 3'b011, 3'b100};
      // Phase C after async reset: default period, enable hold at cnt=1, write on terminal edge.
      tbl[13] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
      tbl[14] = '{3'b000, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
      tbl[15] = '{3'b000, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
      tbl[16] = '{3'b000, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
      tbl[17] = '{3'b000, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
      tbl[18] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
      tbl[19] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b000};
      tbl[20] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b000};
      tbl[21] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b000};
      tbl[22] = '{3'b001, 1'b1, 2'd0, 8'd2, 3'b000, 3'b001, 3'b000};
      tbl[23] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
      tbl[24] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b000};
      tbl[25] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b000};
      tbl[26] = '{3'b001, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001, 3'b000};

      rst = 1'b1; en = '0; wr = 1'b0; wr_ch = '0; wr_half = '0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back('{clk: 3'b000, tick: 3'b000, pend: 3'b000});
      pop_check("reset", 0);
      rst = 1'b0;

      run_range(0, 12);

      // Asynchronous reset between edges: outputs clear with no clock edge.
      #2 rst = 1'b1;
      exp_q.push_back('{clk: 3'b000, tick: 3'b000, pend: 3'b000});
      #1 pop_check("async_rst", 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_range(13, 26);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
